// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: register file with write-through bypass, branch-operand forwarding,
// branch condition and next-PC candidate generation, and the ID/EX pipeline register.
module decode_stage_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_DEPTH      = 32
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [INSTR_WIDTH-1:0]   i_InstrD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4D,
    input  logic                     i_ValidD,
    input  logic                     i_StallD,
    input  logic                     i_FlushE,
    input  logic                     i_RegWriteW,
    input  logic [4:0]               i_WriteRegW,
    input  logic [DATA_WIDTH-1:0]    i_ResultW,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  logic [1:0]               i_ForwardAD,
    input  logic [1:0]               i_ForwardBD,
    input  logic [1:0]               i_BranchOpD,
    input  logic                     i_ExtOpD,
    input  logic [1:0]               i_PC_SELD,
    output logic [ADDRESS_WIDTH-1:0] o_PCD,
    output logic                     o_TakenD,
    output logic                     o_ValidE,
    output logic [DATA_WIDTH-1:0]    o_SrcAE,
    output logic [DATA_WIDTH-1:0]    o_SrcBE,
    output logic [DATA_WIDTH-1:0]    o_ImmE,
    output logic [4:0]               o_RsE,
    output logic [4:0]               o_RtE,
    output logic [4:0]               o_RdE,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4E
);

    localparam int IDX_W = (RF_DEPTH > 2) ? $clog2(RF_DEPTH) : 1;
    localparam logic [5:0] DEPTH = 6'(RF_DEPTH);
    localparam logic signed [DATA_WIDTH-1:0] ZERO = '0;

    localparam logic [1:0] FWD_ALUOUTM = 2'b01;
    localparam logic [1:0] FWD_RESULTW = 2'b10;

    localparam logic [1:0] BR_EQ  = 2'b00;
    localparam logic [1:0] BR_NE  = 2'b01;
    localparam logic [1:0] BR_LEZ = 2'b10;

    localparam logic [1:0] SEL_BRANCH = 2'b00;
    localparam logic [1:0] SEL_REG    = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    function automatic logic in_range(input logic [4:0] addr);
        return (addr != 5'd0) && ({1'b0, addr} < DEPTH);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [15:0] imm, input logic sign);
        return {{(DATA_WIDTH-16){sign & imm[15]}}, imm};
    endfunction

    logic [DATA_WIDTH-1:0] rf [RF_DEPTH];

    logic [4:0]  rs_p0, rt_p0, rd_p0;
    logic [15:0] imm16_p0;
    logic        unused_opcode;

    assign rs_p0    = i_InstrD[25:21];
    assign rt_p0    = i_InstrD[20:16];
    assign rd_p0    = i_InstrD[15:11];
    assign imm16_p0 = i_InstrD[15:0];
    assign unused_opcode = ^i_InstrD[INSTR_WIDTH-1:26];

    // Register file: r0 and addresses beyond RF_DEPTH are hardwired to zero.
    logic wr_en;
    assign wr_en = i_RegWriteW && in_range(i_WriteRegW);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[i_WriteRegW[IDX_W-1:0]] <= i_ResultW;
        end
    end

    logic [DATA_WIDTH-1:0] rd_a_p0, rd_b_p0;

    always_comb begin
        rd_a_p0 = '0;
        if (in_range(rs_p0)) begin
            rd_a_p0 = (wr_en && (i_WriteRegW == rs_p0)) ? i_ResultW : rf[rs_p0[IDX_W-1:0]];
        end
    end

    always_comb begin
        rd_b_p0 = '0;
        if (in_range(rt_p0)) begin
            rd_b_p0 = (wr_en && (i_WriteRegW == rt_p0)) ? i_ResultW : rf[rt_p0[IDX_W-1:0]];
        end
    end

    logic signed [DATA_WIDTH-1:0] cmp_a_p0, cmp_b_p0;

    always_comb begin
        case (i_ForwardAD)
            FWD_ALUOUTM: cmp_a_p0 = i_ALUOutM;
            FWD_RESULTW: cmp_a_p0 = i_ResultW;
            default:     cmp_a_p0 = rd_a_p0;
        endcase
    end

    always_comb begin
        case (i_ForwardBD)
            FWD_ALUOUTM: cmp_b_p0 = i_ALUOutM;
            FWD_RESULTW: cmp_b_p0 = i_ResultW;
            default:     cmp_b_p0 = rd_b_p0;
        endcase
    end

    always_comb begin
        case (i_BranchOpD)
            BR_EQ:   o_TakenD = (cmp_a_p0 == cmp_b_p0);
            BR_NE:   o_TakenD = (cmp_a_p0 != cmp_b_p0);
            BR_LEZ:  o_TakenD = (cmp_a_p0 <= ZERO);
            default: o_TakenD = (cmp_a_p0 > ZERO);
        endcase
    end

    // Branch offset is always sign-extended, independent of i_ExtOpD.
    logic signed [ADDRESS_WIDTH-1:0] br_off_p0;
    logic [ADDRESS_WIDTH-1:0]        br_tgt_p0, jump_tgt_p0, reg_tgt_p0;

    assign br_off_p0  = {{(ADDRESS_WIDTH-18){imm16_p0[15]}}, imm16_p0, 2'b00};
    assign br_tgt_p0  = i_PCPlus4D + br_off_p0;
    assign reg_tgt_p0 = ADDRESS_WIDTH'($unsigned(cmp_a_p0));

    generate
        if (ADDRESS_WIDTH > 28) begin : g_jump_region
            assign jump_tgt_p0 = {i_PCPlus4D[ADDRESS_WIDTH-1:28], i_InstrD[25:0], 2'b00};
        end else begin : g_jump_flat
            assign jump_tgt_p0 = {i_InstrD[25:0], 2'b00};
        end
    endgenerate

    always_comb begin
        case (i_PC_SELD)
            SEL_BRANCH: o_PCD = br_tgt_p0;
            SEL_REG:    o_PCD = reg_tgt_p0;
            SEL_JUMP:   o_PCD = jump_tgt_p0;
            default:    o_PCD = i_PCPlus4D;
        endcase
    end

    // ID/EX boundary: reset > flush > stall > load.
    logic                     vld_p1;
    logic [DATA_WIDTH-1:0]    src_a_p1, src_b_p1, imm_p1;
    logic [4:0]               rs_p1, rt_p1, rd_p1;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_p1;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            vld_p1      <= 1'b0;
            src_a_p1    <= '0;
            src_b_p1    <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            pc_plus4_p1 <= '0;
        end else if (i_FlushE) begin
            vld_p1      <= 1'b0;
            src_a_p1    <= '0;
            src_b_p1    <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            pc_plus4_p1 <= '0;
        end else if (!i_StallD) begin
            vld_p1      <= i_ValidD;
            src_a_p1    <= rd_a_p0;
            src_b_p1    <= rd_b_p0;
            imm_p1      <= extend_imm(imm16_p0, i_ExtOpD);
            rs_p1       <= rs_p0;
            rt_p1       <= rt_p0;
            rd_p1       <= rd_p0;
            pc_plus4_p1 <= i_PCPlus4D;
        end
    end

    assign o_ValidE   = vld_p1;
    assign o_SrcAE    = src_a_p1;
    assign o_SrcBE    = src_b_p1;
    assign o_ImmE     = imm_p1;
    assign o_RsE      = rs_p1;
    assign o_RtE      = rt_p1;
    assign o_RdE      = rd_p1;
    assign o_PCPlus4E = pc_plus4_p1;

endmodule
